// File: rtl/period_counter_pkg.sv
// rtl/period_counter_pkg.sv - shared state encoding and default widths for period_counter
package period_counter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_PRE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/period_counter_if.sv
// rtl/period_counter_if.sv - valid/ready period load channel for period_counter
interface period_counter_if
  import period_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             period_valid;
  logic [WIDTH-1:0] period;
  logic             period_ready;

  modport master (
    output period_valid,
    output period,
    input  period_ready
  );

  modport slave (
    input  period_valid,
    input  period,
    output period_ready
  );

endinterface

// File: rtl/pc_prescaler.sv
// rtl/pc_prescaler.sv - divides clk into one tick every prescale+1 running cycles
module pc_prescaler
  import period_counter_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             r,
  input  logic             clear,
  input  logic             run,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // tick fires on the last cycle of each prescale window while running
  assign tick = run & (cnt == prescale);

  // window counter: cleared by reset/clear, wraps on tick, holds while paused
  always_ff @(posedge clk) begin
    if (r || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/period_counter.sv
// rtl/period_counter.sv - prescaled period counter with shadowed period load; optional capture via PERIOD_COUNTER_CAPTURE_EN
module period_counter
  import period_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic               clk,
  input  logic               r,
  input  logic               en,
  input  logic               stop,
  input  logic               clr,
  input  logic               oneshot,
  input  logic [PRE_W-1:0]   prescale,
  period_counter_if.slave    pif,
  output logic [WIDTH-1:0]   q,
  output logic               tc,
  output logic               busy
`ifdef PERIOD_COUNTER_CAPTURE_EN
  ,
  input  logic               cap_in,
  output logic [WIDTH-1:0]   cap_q,
  output logic               cap_valid
`endif
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] last_q;
  logic             pending;
  logic             os_lat;
  logic             tick;
  logic             run;
  logic             load_fire;
  logic             at_end;
  logic             term;
  logic             start;
  logic [WIDTH-1:0] next_active;

  // a new period may only be refused while one is already queued for the running cycle
  assign pif.period_ready = ~pending;
  assign load_fire        = pif.period_valid & pif.period_ready;
  assign busy             = (state == RUN);
  assign run              = (state == RUN) & en;

  // a load completing in the same cycle as a transfer goes straight to the active register
  assign next_active = load_fire ? pif.period : shadow;

  // period 0 is free-run, so the last count is the all-ones value
  assign last_q = (active == '0) ? '1 : (active - WIDTH'(1));
  assign at_end = (q == last_q);

  // terminal tick; stop and clr both outrank it and swallow the tc
  assign term  = tick & at_end & ~stop & ~clr;
  assign start = (state == IDLE) & en & ~stop;

  pc_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .r        (r),
    .clear    (stop | clr),
    .run      (run),
    .prescale (prescale),
    .tick     (tick)
  );

  // state register
  always_ff @(posedge clk) begin
    if (r) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state: start on en, finish on terminal count in one-shot, abort on stop
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (term && os_lat) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (stop || !en) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // count, terminal pulse, shadow/active period and pending-load bookkeeping
  always_ff @(posedge clk) begin
    if (r) begin
      q       <= '0;
      tc      <= 1'b0;
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      os_lat  <= 1'b0;
    end else begin
      tc <= term;

      if (load_fire) begin
        shadow <= pif.period;
      end

      if (stop || clr) begin
        q <= '0;
      end else if (tick) begin
        q <= at_end ? '0 : (q + WIDTH'(1));
      end

      if (start) begin
        active  <= next_active;
        os_lat  <= oneshot;
        pending <= 1'b0;
      end else if (term) begin
        active  <= next_active;
        pending <= 1'b0;
      end else if (load_fire && (state == RUN)) begin
        pending <= 1'b1;
      end

      if (stop) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef PERIOD_COUNTER_CAPTURE_EN
  logic cap_r;
  logic cap_d;

  // register cap_in once, then snapshot q on its rising edge
  always_ff @(posedge clk) begin
    if (r) begin
      cap_r     <= 1'b0;
      cap_d     <= 1'b0;
      cap_q     <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_r     <= cap_in;
      cap_d     <= cap_r;
      cap_valid <= cap_r & ~cap_d;
      if (cap_r && !cap_d) begin
        cap_q <= q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_period_counter.sv
// tb/tb_period_counter.sv - scoreboard bench for period_counter
module tb_period_counter;
  import period_counter_pkg::*;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          r = 1'b1;
  logic          en = 1'b0;
  logic          stop = 1'b0;
  logic          clr = 1'b0;
  logic          oneshot = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  q;
  logic          tc;
  logic          busy;
`ifdef PERIOD_COUNTER_CAPTURE_EN
  logic          cap_in = 1'b0;
  logic [W-1:0]  cap_q;
  logic          cap_valid;
`endif

  period_counter_if #(.WIDTH(W)) pif ();

  period_counter #(
    .WIDTH (W),
    .PRE_W (PW)
  ) dut (
    .clk      (clk),
    .r        (r),
    .en       (en),
    .stop     (stop),
    .clr      (clr),
    .oneshot  (oneshot),
    .prescale (prescale),
    .pif      (pif.slave),
    .q        (q),
    .tc       (tc),
    .busy     (busy)
`ifdef PERIOD_COUNTER_CAPTURE_EN
    ,
    .cap_in    (cap_in),
    .cap_q     (cap_q),
    .cap_valid (cap_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         ready;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int tc_cnt = 0;

  state_t       m_state = IDLE;
  logic [W-1:0] m_q = '0, m_shadow = '0, m_act = '0;
  logic [PW-1:0] m_pre = '0;
  logic         m_tc = 1'b0, m_pend = 1'b0, m_os = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic fire, tk, xfer;
    logic [W-1:0] nshadow, last;
    exp_t e;
    if (r) begin
      m_state = IDLE; m_q = '0; m_pre = '0; m_tc = 1'b0;
      m_shadow = '0; m_act = '0; m_pend = 1'b0; m_os = 1'b0;
    end else begin
      fire    = pif.period_valid && !m_pend;
      nshadow = fire ? pif.period : m_shadow;
      tk      = 1'b0;
      xfer    = 1'b0;
      m_tc    = 1'b0;
      if (stop) begin
        m_q = '0; m_pre = '0; m_pend = 1'b0; m_state = IDLE;
      end else begin
        if (m_state == RUN && en) begin
          if (m_pre == prescale) begin
            tk = 1'b1; m_pre = '0;
          end else begin
            m_pre = m_pre + 1'b1;
          end
        end
        if (clr) begin
          m_q = '0; m_pre = '0; tk = 1'b0;
        end
        if (tk) begin
          last = (m_act == 0) ? {W{1'b1}} : m_act - 1'b1;
          if (m_q == last) begin
            m_q = '0; m_tc = 1'b1; xfer = 1'b1;
          end else begin
            m_q = m_q + 1'b1;
          end
        end
        case (m_state)
          IDLE: if (en) begin m_state = RUN; xfer = 1'b1; m_os = oneshot; end
          RUN:  if (m_tc && m_os) m_state = DONE;
          DONE: if (!en) m_state = IDLE;
          default: m_state = IDLE;
        endcase
        if (xfer) begin
          m_act = nshadow; m_pend = 1'b0;
        end else if (fire && m_state == RUN) begin
          m_pend = 1'b1;
        end
      end
      m_shadow = nshadow;
    end
    e.q = m_q; e.tc = m_tc; e.busy = (m_state == RUN); e.ready = !m_pend;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("q", q, e.q);
    chk("tc", tc, e.tc);
    chk("busy", busy, e.busy);
    chk("ready", pif.period_ready, e.ready);
    if (tc) tc_cnt++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [W-1:0] p);
    pif.period_valid = 1'b1;
    pif.period = p;
    step();
    pif.period_valid = 1'b0;
  endtask

  initial begin
    pif.period_valid = 1'b0;
    pif.period = '0;

    run_n(2);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", pif.period_ready, 1);
    r = 1'b0;

    // period 5, prescale 0, continuous
    load(4'd5);
    en = 1'b1;
    tc_cnt = 0;
    run_n(21);
    chk("p5_tc_count", tc_cnt, 4);
    chk("p5_busy", busy, 1);
    en = 1'b0; stop = 1'b1; step(); stop = 1'b0;

    // period 3, prescale 2, one-shot
    load(4'd3);
    prescale = 4'd2; oneshot = 1'b1; en = 1'b1;
    tc_cnt = 0;
    run_n(12);
    chk("os_tc_count", tc_cnt, 1);
    chk("os_busy", busy, 0);
    chk("os_q", q, 0);
    en = 1'b0; oneshot = 1'b0; prescale = '0; step();

    // free-run period 0 wraps 15 -> 0
    load(4'd0);
    en = 1'b1; tc_cnt = 0;
    run_n(17);
    chk("free_tc_count", tc_cnt, 1);
    en = 1'b0; stop = 1'b1; step(); stop = 1'b0;

    // period 1: tc on every tick, q stays 0
    load(4'd1);
    en = 1'b1; tc_cnt = 0;
    run_n(6);
    chk("p1_tc_count", tc_cnt, 5);
    chk("p1_q", q, 0);
    en = 1'b0; stop = 1'b1; step(); stop = 1'b0;

    // period 8 running, load 4 at q=2, refused reload while pending
    load(4'd8);
    en = 1'b1;
    run_n(3);
    chk("p8_q2", q, 2);
    load(4'd4);
    chk("pend_ready", pif.period_ready, 0);
    load(4'd9);
    run_n(4);
    chk("pend_tc", tc, 1);
    chk("pend_cleared", pif.period_ready, 1);
    tc_cnt = 0;
    run_n(8);
    chk("p4_tc_count", tc_cnt, 2);
    run_n(2);
    chk("p4_q2", q, 2);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_q", q, 0);
    chk("stop_busy", busy, 0);
    step();
    chk("stop_no_tc", tc, 0);
    en = 1'b0; step();

    // clr on terminal tick, pause, then reset mid-run
    load(4'd5);
    en = 1'b1;
    run_n(5);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_q", q, 0);
    step();
    chk("clr_no_tc", tc, 0);
    en = 1'b0; run_n(3);
    en = 1'b1; run_n(2);
    r = 1'b1; step(); r = 1'b0;
    chk("rmid_q", q, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_tc", tc, 0);
    en = 1'b0; step();

    // random mix against the model
    for (int i = 0; i < 400; i++) begin
      en               = ($urandom_range(0, 9) != 0);
      stop             = ($urandom_range(0, 39) == 0);
      clr              = ($urandom_range(0, 29) == 0);
      r                = ($urandom_range(0, 99) == 0);
      oneshot          = ($urandom_range(0, 3) == 0);
      prescale         = PW'($urandom_range(0, 2));
      pif.period_valid = ($urandom_range(0, 5) == 0);
      pif.period       = W'($urandom_range(0, 7));
      step();
    end
    en = 1'b0; stop = 1'b0; clr = 1'b0; r = 1'b0; pif.period_valid = 1'b0; prescale = '0;
    oneshot = 1'b0;

`ifdef PERIOD_COUNTER_CAPTURE_EN
    begin
      int vcnt;
      logic [W-1:0] got;
      stop = 1'b1; step(); stop = 1'b0;
      load(4'd10);
      en = 1'b1;
      run_n(7);
      chk("cap_pre_q", q, 6);
      cap_in = 1'b1;
      vcnt = 0; got = '0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (cap_valid) begin vcnt++; got = cap_q; end
      end
      cap_in = 1'b0;
      chk("cap_valid_cnt", vcnt, 1);
      chk("cap_q_ok", (got == 4'd6) || (got == 4'd7), 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/period_counter.md
PERIOD_COUNTER -- requirements
Module: period_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter/period width (2..64).
REQ-002 SHALL have parameter PRE_W, default 8, prescaler width.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port r  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  in  1  start/run enable; low pauses counting.
REQ-006 SHALL have port stop  in  1  abort: clear count, return to IDLE.
REQ-007 SHALL have port clr  in  1  clear count and prescaler, state unchanged.
REQ-008 SHALL have port oneshot  in  1  1 = stop after first terminal count; sampled on IDLE->RUN.
REQ-009 SHALL have port prescale  in  PRE_W  tick every prescale+1 clk cycles.
REQ-010 SHALL have ports period_valid in 1 / period in WIDTH / period_ready out 1  valid-ready period load.
REQ-011 SHALL have port q  out  WIDTH  current count.
REQ-012 SHALL have port tc  out  1  one-cycle terminal-count pulse.
REQ-013 SHALL have port busy  out  1  high in RUN.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE->RUN when en=1 and stop=0; active period <= shadow period, oneshot latched.
REQ-016 RUN->DONE on tc when oneshot latched; RUN->IDLE on stop; DONE->IDLE when en=0 or stop=1.
REQ-017 In RUN with en=1, prescaler counts 0..prescale; tick asserted on cycle prescaler==prescale, prescaler then wraps to 0.
REQ-018 On tick: if q == active_period-1, q<=0 and tc=1 next cycle; else q<=q+1.
REQ-019 active_period==0 SHALL mean free-run: q wraps 2^WIDTH-1 -> 0 with tc on wrap.
REQ-020 active_period==1 SHALL give tc on every tick, q held at 0.
REQ-021 In RUN with en=0, q and prescaler SHALL hold; no tc.
REQ-022 Load handshake completes when period_valid & period_ready; value written to shadow register.
REQ-023 period_ready SHALL be 0 only while a shadow value is pending in RUN; pending clears when shadow is transferred.
REQ-024 Shadow SHALL transfer to active on tc and on IDLE->RUN; a load accepted in the tc cycle becomes active at that tc.
REQ-025 Priority: r > stop > clr > tick; clr coincident with terminal tick SHALL suppress tc.
REQ-026 stop SHALL clear q, prescaler and pending flag, never emit tc.
REQ-027 In IDLE and DONE, q SHALL hold its last value except clr/stop/r clear it.

Reset
REQ-028 On r=1 at clock edge: state=IDLE, q=0, prescaler=0, tc=0, busy=0, shadow=active=0, pending=0, period_ready=1.
REQ-029 r asserted mid-RUN SHALL take effect that edge, overriding every other input.

Configuration
REQ-030 Macro PERIOD_COUNTER_CAPTURE_EN SHALL add ports cap_in (in 1), cap_q (out WIDTH), cap_valid (out 1).
REQ-031 With macro: cap_in registered once; on registered rising edge cap_q<=q and cap_valid=1 one cycle; reset values 0.
REQ-032 Without macro: capture ports and logic absent; all other behaviour identical.

Structure
REQ-033 Package period_counter_pkg SHALL hold the state enum (IDLE/RUN/DONE) and default WIDTH/PRE_W constants.
REQ-034 Prescaler SHALL be a sub-module, pc_prescaler (inputs clk, r, clear, run, prescale; output tick).

Verification
REQ-035 Period 5, prescale 0, oneshot 0, en 1 -> q 0,1,2,3,4,0..., tc every 5th cycle, busy 1.
REQ-036 Period 3, prescale 2, oneshot 1 -> q advances every 3 clk, single tc after 9 clk, state DONE, busy 0, q 0.
REQ-037 Period 0, WIDTH 4 -> q wraps 15->0 with tc; period 1 -> tc every tick, q stays 0.
REQ-038 Period 8 running, load 4 at q=2 -> period_ready 0 until tc at q=7, then cycle of 4; stop at q=2 -> q=0, IDLE, no tc.
REQ-039 clr at q==period-1 tick -> q=0, no tc; r mid-RUN -> all outputs to reset values next edge.
REQ-040 With PERIOD_COUNTER_CAPTURE_EN, cap_in rise at q=6 (period 10) -> cap_q=6 or 7 per register latency, cap_valid one cycle.
